// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the push-button conditioning used by the dice-simulator blocks.
package key_conditioner_pkg;

  // Per-key debounce FSM states.
  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } key_state_e;

  // Push-buttons are active-low.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Debounce counter width for a given stable-cycle requirement.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: synchronizer chain, debounce FSM and saturating stable-level counter.
// strobe_o is a registered one-cycle pulse on an accepted press; held_o follows the FSM state.
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1000000,
  parameter int unsigned SyncStages     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic strobe_o,
  output logic held_o
);

  localparam int unsigned     CntW   = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  level;
  key_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_inc;
  logic                  cnt_done;
  logic                  strobe_q;

  // Synchronizer chain; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], key_i};
    end
  end

  assign level = sync_q[SyncStages-1];

  // Saturating increment; done when this cycle's count reaches DebounceCycles-1.
  always_comb begin
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    cnt_done = (cnt_inc == CntMax);
  end

  // Debounce FSM with registered press strobe; release produces no strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StReleased;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        StReleased: begin
          if (level == KEY_PRESSED) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (level != KEY_PRESSED) begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_done) begin
              state_q  <= StPressed;
              strobe_q <= 1'b1;
            end
          end
        end
        StPressed: begin
          if (level != KEY_PRESSED) begin
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end
        end
        StReleaseWait: begin
          if (level == KEY_PRESSED) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_done) begin
              state_q <= StReleased;
            end
          end
        end
        default: begin
          state_q <= StReleased;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign strobe_o = strobe_q;
  assign held_o   = (state_q == StPressed) || (state_q == StReleaseWait);

endmodule

// File: rtl/key_conditioner.sv
// Conditions three raw push-buttons into inc/throw/dec strobes plus a held level for throw.
// Simultaneous inc and dec presses cancel; throw is independent of both.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic KEY0,
  input  logic KEY1,
  input  logic KEY2,
  output logic inc_pulse,
  output logic throw_pulse,
  output logic dec_pulse,
  output logic throw_held
);

  logic strobe0, strobe1, strobe2;
  logic held0, held1, held2;
  logic unused_held;
  logic inc_q, throw_q, dec_q, held_q;

  key_debounce #(
    .DebounceCycles(DEBOUNCE_CYCLES),
    .SyncStages    (SYNC_STAGES)
  ) u_key0 (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .key_i   (KEY0),
    .strobe_o(strobe0),
    .held_o  (held0)
  );

  key_debounce #(
    .DebounceCycles(DEBOUNCE_CYCLES),
    .SyncStages    (SYNC_STAGES)
  ) u_key1 (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .key_i   (KEY1),
    .strobe_o(strobe1),
    .held_o  (held1)
  );

  key_debounce #(
    .DebounceCycles(DEBOUNCE_CYCLES),
    .SyncStages    (SYNC_STAGES)
  ) u_key2 (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .key_i   (KEY2),
    .strobe_o(strobe2),
    .held_o  (held2)
  );

  // Only the throw key exposes a held level.
  assign unused_held = held0 ^ held2;

  // Output stage: drop coincident inc/dec strobes, pass throw and its held level through.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      inc_q   <= 1'b0;
      throw_q <= 1'b0;
      dec_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      inc_q   <= strobe0 & ~strobe2;
      dec_q   <= strobe2 & ~strobe0;
      throw_q <= strobe1;
      held_q  <= held1;
    end
  end

  assign inc_pulse   = inc_q;
  assign throw_pulse = throw_q;
  assign dec_pulse   = dec_q;
  assign throw_held  = held_q;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int Debounce = 4;
  localparam int Sync     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key0  = 1'b1;
  logic key1  = 1'b1;
  logic key2  = 1'b1;
  logic inc_pulse, throw_pulse, dec_pulse, throw_held;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYCLES(Debounce),
    .SYNC_STAGES    (Sync)
  ) u_dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .KEY0       (key0),
    .KEY1       (key1),
    .KEY2       (key2),
    .inc_pulse  (inc_pulse),
    .throw_pulse(throw_pulse),
    .dec_pulse  (dec_pulse),
    .throw_held (throw_held)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: each key sees its input delayed by Sync edges, and the accepted level
  // flips after Debounce consecutive observations that disagree with it. Outputs follow one
  // edge later.
  bit [Sync-1:0] dly_m [3];
  bit            acc_m [3];
  int            run_m [3];
  bit            pend_m[3];
  bit [2:0]      kin;
  bit            lvl_m;
  bit            e_inc, e_thr, e_dec, e_held;

  always @(posedge clk) begin
    kin = {key2, key1, key0};
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        dly_m[k]  = '1;
        acc_m[k]  = 1'b1;
        run_m[k]  = 0;
        pend_m[k] = 1'b0;
      end
      e_inc = 0; e_thr = 0; e_dec = 0; e_held = 0;
    end else begin
      e_inc  = pend_m[0] && !pend_m[2];
      e_dec  = pend_m[2] && !pend_m[0];
      e_thr  = pend_m[1];
      e_held = !acc_m[1];
      for (int k = 0; k < 3; k++) begin
        lvl_m     = dly_m[k][Sync-1];
        pend_m[k] = 1'b0;
        if (lvl_m != acc_m[k]) begin
          run_m[k]++;
          if (run_m[k] == Debounce) begin
            acc_m[k]  = lvl_m;
            run_m[k]  = 0;
            pend_m[k] = (lvl_m == 1'b0);
          end
        end else begin
          run_m[k] = 0;
        end
        dly_m[k] = {dly_m[k][Sync-2:0], kin[k]};
      end
    end
    #1;
    check("model_inc_pulse", inc_pulse, e_inc);
    check("model_throw_pulse", throw_pulse, e_thr);
    check("model_dec_pulse", dec_pulse, e_dec);
    check("model_throw_held", throw_held, e_held);
  end

  task automatic settle();
    key0 = 1'b1; key1 = 1'b1; key2 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  int cnt_a, cnt_b, max_cnt;
  int rem[3];
  logic [2:0] kv;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_inc", inc_pulse, 0);
    check("reset_throw", throw_pulse, 0);
    check("reset_dec", dec_pulse, 0);
    check("reset_held", throw_held, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single KEY0 press: pulse exactly 7 cycles after the fall, none on release
    key0 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("t1_inc_press", inc_pulse, 32'(i == 7));
    end
    key0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("t1_inc_release", inc_pulse, 0);
    end

    // KEY1 bounce then steady hold
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (throw_pulse) cnt_a++;
      key1 = ((i / 2) % 2 == 1);
    end
    check("t2_bounce_pulses", cnt_a, 0);
    cnt_b = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (throw_pulse) cnt_b++;
    end
    check("t2_hold_pulses", cnt_b, 1);
    check("t2_held_on", throw_held, 1);
    key1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("t2_held_release", throw_held, 32'(i < 7));
      check("t2_no_release_pulse", throw_pulse, 0);
    end
    settle();

    // KEY0 and KEY2 together cancel; staggered by 3 both pass
    key0 = 1'b0; key2 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("t3_conflict_inc", inc_pulse, 0);
      check("t3_conflict_dec", dec_pulse, 0);
    end
    settle();
    key0 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3) key2 = 1'b0;
      check("t3_stagger_inc", inc_pulse, 32'(i == 7));
      check("t3_stagger_dec", dec_pulse, 32'(i == 10));
    end
    settle();

    // KEY1 and KEY2 together both strobe
    key1 = 1'b0; key2 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("t4_throw", throw_pulse, 32'(i == 7));
      check("t4_dec", dec_pulse, 32'(i == 7));
    end
    settle();

    // Reset mid-debounce with KEY0 still held
    key0 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b0;
      if (i == 4) rst_n = 1'b1;
      check("t5_reset_inc", inc_pulse, 32'(i == 11));
    end
    settle();

    // Long hold: single strobe, counter saturates at Debounce-1
    key2 = 1'b0;
    cnt_a = 0; max_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dec_pulse) cnt_a++;
      if (int'(u_dut.u_key2.cnt_q) > max_cnt) max_cnt = int'(u_dut.u_key2.cnt_q);
    end
    check("t6_long_hold_pulses", cnt_a, 1);
    check("t6_counter_saturation", max_cnt, Debounce - 1);
    settle();

    // Randomized runs on all keys with occasional resets
    for (int k = 0; k < 3; k++) rem[k] = 0;
    kv = 3'b111;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 14))
                                                : int'($urandom_range(1, 5));
          kv[k] = 1'($urandom_range(0, 1));
        end
        rem[k]--;
      end
      key0 = kv[0]; key1 = kv[1]; key2 = kv[2];
    end
    rst_n = 1'b1;
    settle();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
